// File: rtl/lfsr_word_collector.sv
// Serial-to-parallel collector for the lfsr500 chain output.
// Packs sampled bits MSB-first into words, keeps a CRC-16 signature and a word count.
module lfsr_word_collector #(
    parameter int unsigned WORD_W   = 32,
    parameter logic [15:0] SIG_POLY = 16'h1021,
    parameter logic [15:0] SIG_SEED = 16'hFFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              en,
    input  logic              sin,
    input  logic              word_ready,
    output logic [WORD_W-1:0] word_data,
    output logic              word_valid,
    output logic              overrun,
    output logic [15:0]       signature,
    output logic [15:0]       word_cnt
);

    localparam int unsigned IDX_W = (WORD_W > 2) ? $clog2(WORD_W) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(WORD_W - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_e;

    slot_e              state_q, state_d;
    logic [WORD_W-2:0]  sreg_q, sreg_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WORD_W-1:0]  data_q, data_d;
    logic               ovr_q, ovr_d;
    logic [15:0]        sig_q, sig_d;
    logic [15:0]        cnt_q, cnt_d;

    logic [WORD_W-1:0]  word_c;
    logic               done_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            sreg_q  <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            ovr_q   <= 1'b0;
            sig_q   <= SIG_SEED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            ovr_q   <= ovr_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
        end
    end

    // Fill path and signature advance on every accepted strobe.
    always_comb begin
        word_c = {sreg_q, sin};
        done_c = en && !clear && (idx_q == LAST);
        sreg_d = sreg_q;
        idx_d  = idx_q;
        sig_d  = sig_q;
        if (clear) begin
            sreg_d = '0;
            idx_d  = '0;
            sig_d  = SIG_SEED;
        end else if (en) begin
            sig_d  = {sig_q[14:0], 1'b0}
                   ^ ((sig_q[15] ^ sin) ? SIG_POLY : 16'h0000);
            sreg_d = word_c[WORD_W-2:0];
            idx_d  = done_c ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Output slot: a completed word is dropped only when the slot is held.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ovr_d   = ovr_q;
        cnt_d   = cnt_q;
        if (clear) begin
            state_d = EMPTY;
            ovr_d   = 1'b0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (done_c) begin
                        state_d = FULL;
                        data_d  = word_c;
                        cnt_d   = cnt_q + 16'd1;
                    end
                end
                FULL: begin
                    if (word_ready) begin
                        if (done_c) begin
                            data_d = word_c;
                            cnt_d  = cnt_q + 16'd1;
                        end else begin
                            state_d = EMPTY;
                        end
                    end else if (done_c) begin
                        ovr_d = 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        word_valid = (state_q == FULL);
        word_data  = data_q;
        overrun    = ovr_q;
        signature  = sig_q;
        word_cnt   = cnt_q;
    end

endmodule

// File: tb/tb_lfsr_word_collector.sv
// Bench for lfsr_word_collector: scoreboard of delivered words plus direct
// checks of count, overrun, signature and reset behaviour.
module tb_lfsr_word_collector;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        en;
    logic        sin;
    logic        word_ready;
    logic [31:0] word_data;
    logic        word_valid;
    logic        overrun;
    logic [15:0] signature;
    logic [15:0] word_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [15:0] sig_m;

    lfsr_word_collector #(
        .WORD_W  (32),
        .SIG_POLY(16'h1021),
        .SIG_SEED(16'hFFFF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .en        (en),
        .sin       (sin),
        .word_ready(word_ready),
        .word_data (word_data),
        .word_valid(word_valid),
        .overrun   (overrun),
        .signature (signature),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One strobe; the bench keeps its own CRC of every sampled bit.
    task automatic send_bit(input logic b, input int gap);
        logic fb;
        en  = 1'b1;
        sin = b;
        fb  = sig_m[15] ^ b;
        sig_m = {sig_m[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        tick();
        en = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_word(input logic [31:0] w, input bit push,
                             input bit sparse);
        if (push) exp_q.push_back(w);
        for (int i = 31; i >= 0; i--) begin
            send_bit(w[i], sparse ? int'($urandom_range(1, 3)) : 0);
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        sig_m = 16'hFFFF;
    endtask

    // Words are compared against the scoreboard as they are accepted.
    always @(negedge clk) begin
        if (reset && word_valid && word_ready) begin
            if (exp_q.size() == 0) chk("sb_extra", word_data, 32'hx);
            else chk("sb_word", word_data, exp_q.pop_front());
        end
    end

    initial begin
        logic [71:0] ascii;
        logic [31:0] w;
        reset = 1'b0;
        clear = 1'b0;
        en = 1'b0;
        sin = 1'b0;
        word_ready = 1'b0;
        sig_m = 16'hFFFF;
        repeat (3) tick();
        reset = 1'b1;
        repeat (2) tick();
        chk("rst_valid", 32'(word_valid), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        chk("rst_cnt", 32'(word_cnt), 32'd0);
        chk("rst_sig", 32'(signature), 32'h0000FFFF);
        chk("rst_data", word_data, 32'd0);

        // Single word, en held high
        word_ready = 1'b1;
        send_word(32'hA5F00F5A, 1'b1, 1'b0);
        chk("sw_valid", 32'(word_valid), 32'd1);
        chk("sw_data", word_data, 32'hA5F00F5A);
        chk("sw_cnt", 32'(word_cnt), 32'd1);
        chk("sw_sig", 32'(signature), 32'(sig_m));
        tick();
        chk("sw_pulse", 32'(word_valid), 32'd0);

        // Sparse strobe
        w = 32'hA5F00F5A;
        exp_q.push_back(w);
        for (int i = 31; i >= 1; i--)
            send_bit(w[i], int'($urandom_range(1, 3)));
        chk("sp_early", 32'(word_valid), 32'd0);
        send_bit(w[0], 0);
        chk("sp_valid", 32'(word_valid), 32'd1);
        chk("sp_data", word_data, 32'hA5F00F5A);
        chk("sp_cnt", 32'(word_cnt), 32'd2);
        tick();

        // Backpressure and overrun
        do_clear();
        chk("clr_cnt", 32'(word_cnt), 32'd0);
        chk("clr_sig", 32'(signature), 32'h0000FFFF);
        word_ready = 1'b0;
        send_word(32'h00000001, 1'b1, 1'b0);
        send_word(32'hFFFFFFFF, 1'b0, 1'b0);
        chk("bp_data", word_data, 32'h00000001);
        chk("bp_valid", 32'(word_valid), 32'd1);
        chk("bp_ovr", 32'(overrun), 32'd1);
        chk("bp_cnt", 32'(word_cnt), 32'd1);
        chk("bp_sig", 32'(signature), 32'(sig_m));
        word_ready = 1'b1;
        tick();
        chk("bp_fall", 32'(word_valid), 32'd0);
        chk("bp_sticky", 32'(overrun), 32'd1);

        // Accept and complete in the same cycle
        do_clear();
        chk("clr_ovr", 32'(overrun), 32'd0);
        word_ready = 1'b0;
        send_word(32'hCAFEBABE, 1'b1, 1'b0);
        w = 32'h13572468;
        exp_q.push_back(w);
        for (int i = 31; i >= 1; i--) send_bit(w[i], 0);
        word_ready = 1'b1;
        send_bit(w[0], 0);
        word_ready = 1'b0;
        chk("sim_valid", 32'(word_valid), 32'd1);
        chk("sim_data", word_data, 32'h13572468);
        chk("sim_cnt", 32'(word_cnt), 32'd2);
        chk("sim_ovr", 32'(overrun), 32'd0);
        word_ready = 1'b1;
        tick();
        chk("sim_fall", 32'(word_valid), 32'd0);

        // CRC check string, then reset part way through a word
        do_clear();
        ascii = 72'h313233343536373839;
        exp_q.push_back(32'h31323334);
        exp_q.push_back(32'h35363738);
        for (int i = 71; i >= 0; i--) send_bit(ascii[i], 0);
        chk("crc_const", 32'(signature), 32'h000029B1);
        chk("crc_model", 32'(signature), 32'(sig_m));
        chk("crc_cnt", 32'(word_cnt), 32'd2);
        for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(0, 1)), 0);
        reset = 1'b0;
        #2;
        chk("ar_sig", 32'(signature), 32'h0000FFFF);
        chk("ar_cnt", 32'(word_cnt), 32'd0);
        chk("ar_data", word_data, 32'd0);
        tick();
        reset = 1'b1;
        sig_m = 16'hFFFF;
        tick();
        send_word(32'h12345678, 1'b1, 1'b0);
        chk("mr_data", word_data, 32'h12345678);
        chk("mr_cnt", 32'(word_cnt), 32'd1);
        chk("mr_sig", 32'(signature), 32'(sig_m));
        repeat (3) tick();
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
